layer_compositor_n: RTL and testbench
=====================================

Name: layer_compositor_n

Overview:
- Parametrised, pipelined priority compositor for the VGA path; successor to the fixed 6-input objects mux.
- Takes N_LAYERS object layers (drawing request + 8-bit RRRGGGBB colour each) plus background.
- Per-layer enable and blink, colour-key transparency, frame-synchronous config update.
- Outputs 24-bit RGB and the index of the winning layer; sits between object generators and the VGA controller.

Parameters:
- N_LAYERS, 6: number of object layers; index 0 is highest priority.
- TRANSPARENT_RGB, 8'hFF: layer colour treated as "not drawing".
- BLINK_FRAMES, 30: frames per blink half-period (≥1).
- IDX_W, $clog2(N_LAYERS) (min 1): width of the winning-index output.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- drawingRequest  in  N_LAYERS  per-layer request, bit i = layer i
- layerRGB  in  8*N_LAYERS  layer i colour at [8*i+7:8*i]
- backGroundRGB  in  8  lowest-priority colour
- startOfFrame  in  1  one-cycle pulse at first pixel of frame
- cfgWrite  in  1  strobe: capture cfgEnable/cfgBlinkMask into shadow
- cfgEnable  in  N_LAYERS  requested layer enables
- cfgBlinkMask  in  N_LAYERS  requested blink mask
- cfgPending  out  1  shadow holds config not yet applied
- redOut  out  8  expanded red
- greenOut  out  8  expanded green
- blueOut  out  8  expanded blue
- topLayer  out  IDX_W  winning layer index, 0 when none
- topLayerValid  out  1  1 = a layer won, 0 = background shown

Behaviour:
- Reset (async, resetN=0):
  - All colour outputs, topLayer, topLayerValid, and pipeline registers = 0.
  - Active enable = all ones, active blink mask = 0; shadow copies equal the active values.
  - cfgPending=0, blinkPhase=0, frameCnt=0.
- Effective request i = drawingRequest[i] & enable[i] & (layerRGB_i != TRANSPARENT_RGB) & ~(blinkMask[i] & blinkPhase).
- Selection: lowest i with effective request wins; no winner → backGroundRGB, topLayerValid=0, topLayer=0.
- Pipeline, fixed latency 2 cycles:
  - Stage 1 registers the selected 8-bit colour, index and valid.
  - Stage 2 registers the expanded outputs and index/valid.
  - Inputs sampled at edge k appear on the outputs after edge k+1.
- Expansion:
  - red = {c[7:5], 5×c[5]}
  - green = {c[4:2], 5×c[2]}
  - blue = {c[1:0], 6×c[0]}
- Config update:
  - cfgWrite loads the shadow registers and sets cfgPending=1.
  - On startOfFrame, the active registers load from the shadow and cfgPending clears.
  - cfgWrite in the same cycle as startOfFrame: the new values go straight to active and cfgPending stays 0.
  - Multiple writes within a frame: last write wins.
  - Active config never changes mid-frame.
- Blink counter:
  - Each startOfFrame increments frameCnt.
  - When frameCnt == BLINK_FRAMES-1 it wraps to 0 and blinkPhase toggles.
  - BLINK_FRAMES=1 toggles every frame.
  - The new blinkPhase and the new config affect pixels sampled from the cycle after the startOfFrame edge.
- All registers are in a single clock domain; no combinational path from inputs to outputs.
- Reset mid-frame clears the pipeline immediately. The first post-reset outputs are valid 2 cycles after the first sampled input.

Test Plan:
- Reset, then drawingRequest=6'b000000, backGroundRGB=8'h1C → after 2 clocks red=8'h00, green=8'hFF, blue=8'h00, topLayerValid=0, topLayer=0.
- drawingRequest=6'b001010, layer1=8'hE0, layer3=8'h03 → after 2 clocks red=8'hFF, green=8'h00, blue=8'h00, topLayer=1, valid=1.
- Layer1=TRANSPARENT_RGB (8'hFF) with the same requests → layer3 wins: blue=8'hFF, topLayer=3.
- cfgWrite with cfgEnable=6'b111101 mid-frame:
  - cfgPending=1 and layer 1 still wins until startOfFrame.
  - After startOfFrame, cfgPending=0 and layer 3 wins.
  - Repeat with cfgWrite coincident with startOfFrame: cfgPending never asserts.
- BLINK_FRAMES=2, cfgBlinkMask=6'b000010 applied, layer1 requesting:
  - Layer1 is visible for frames 0–1, hidden for frames 2–3 (layer3/background shown), visible again from frame 4.
- Assert resetN=0 mid-stream with layer0 winning → outputs 0 asynchronously; after release, active enable = 6'b111111 and blinkPhase=0.

Source files
------------

// File: rtl/layer_compositor_n.sv
// Pipelined priority compositor: picks the highest-priority visible layer (index 0 first)
// over the background, with frame-synchronous enable/blink config and 8->24 bit colour expansion.
`timescale 1ns/1ps
module layer_compositor_n #(
  parameter int          N_LAYERS        = 6,
  parameter logic [7:0]  TRANSPARENT_RGB = 8'hFF,
  parameter int          BLINK_FRAMES    = 30,
  parameter int          IDX_W           = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [N_LAYERS-1:0]     drawingRequest,
  input  logic [8*N_LAYERS-1:0]   layerRGB,
  input  logic [7:0]              backGroundRGB,
  input  logic                    startOfFrame,
  input  logic                    cfgWrite,
  input  logic [N_LAYERS-1:0]     cfgEnable,
  input  logic [N_LAYERS-1:0]     cfgBlinkMask,
  output logic                    cfgPending,
  output logic [7:0]              redOut,
  output logic [7:0]              greenOut,
  output logic [7:0]              blueOut,
  output logic [IDX_W-1:0]        topLayer,
  output logic                    topLayerValid
);

  localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [N_LAYERS-1:0] enable_reg, blink_mask_reg;
  logic [N_LAYERS-1:0] shadow_enable_reg, shadow_blink_reg;
  logic                pending_reg;
  logic [CNT_W-1:0]    frame_cnt_reg;
  logic                blink_phase_reg;

  logic [7:0]          layer_color [N_LAYERS];
  logic [N_LAYERS-1:0] eff_req;

  logic [7:0]          sel_rgb;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_valid;

  logic [7:0]          s1_rgb_reg;
  logic [IDX_W-1:0]    s1_idx_reg;
  logic                s1_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_LAYERS; gi++) begin : g_layer
      assign layer_color[gi] = layerRGB[8*gi +: 8];
      assign eff_req[gi] = drawingRequest[gi] & enable_reg[gi]
                         & (layerRGB[8*gi +: 8] != TRANSPARENT_RGB)
                         & ~(blink_mask_reg[gi] & blink_phase_reg);
    end
  endgenerate

  // Scan from lowest priority upward so the lowest requesting index is the final assignment
  always_comb begin
    sel_rgb   = backGroundRGB;
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (eff_req[i]) begin
        sel_rgb   = layer_color[i];
        sel_idx   = IDX_W'(i);
        sel_valid = 1'b1;
      end
    end
  end

  // A write coinciding with start-of-frame bypasses the shadow straight into the active set
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      enable_reg        <= '1;
      blink_mask_reg    <= '0;
      shadow_enable_reg <= '1;
      shadow_blink_reg  <= '0;
      pending_reg       <= 1'b0;
    end else begin
      if (cfgWrite) begin
        shadow_enable_reg <= cfgEnable;
        shadow_blink_reg  <= cfgBlinkMask;
      end
      if (startOfFrame) begin
        enable_reg     <= cfgWrite ? cfgEnable    : shadow_enable_reg;
        blink_mask_reg <= cfgWrite ? cfgBlinkMask : shadow_blink_reg;
        pending_reg    <= 1'b0;
      end else if (cfgWrite) begin
        pending_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (startOfFrame) begin
      if (frame_cnt_reg == CNT_LAST) begin
        frame_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_rgb_reg    <= '0;
      s1_idx_reg    <= '0;
      s1_valid_reg  <= 1'b0;
      redOut        <= '0;
      greenOut      <= '0;
      blueOut       <= '0;
      topLayer      <= '0;
      topLayerValid <= 1'b0;
    end else begin
      s1_rgb_reg    <= sel_rgb;
      s1_idx_reg    <= sel_idx;
      s1_valid_reg  <= sel_valid;
      redOut        <= {s1_rgb_reg[7:5], {5{s1_rgb_reg[5]}}};
      greenOut      <= {s1_rgb_reg[4:2], {5{s1_rgb_reg[2]}}};
      blueOut       <= {s1_rgb_reg[1:0], {6{s1_rgb_reg[0]}}};
      topLayer      <= s1_idx_reg;
      topLayerValid <= s1_valid_reg;
    end
  end

  assign cfgPending = pending_reg;

endmodule

// File: tb/tb_layer_compositor_n.sv
// Directed plus randomized bench for layer_compositor_n, checked against a frame-level
// behavioural model of priority selection, config shadowing and blink timing.
`timescale 1ns/1ps
module tb_layer_compositor_n;

  localparam int BF = 2;

  logic        clk;
  logic        resetN;
  logic [5:0]  drawingRequest;
  logic [47:0] layerRGB;
  logic [7:0]  backGroundRGB;
  logic        startOfFrame;
  logic        cfgWrite;
  logic [5:0]  cfgEnable;
  logic [5:0]  cfgBlinkMask;
  logic        cfgPending;
  logic [7:0]  redOut, greenOut, blueOut;
  logic [2:0]  topLayer;
  logic        topLayerValid;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [5:0]  m_en, m_mask, m_sh_en, m_sh_mask;
  logic        m_pend;
  int          m_sofs;
  logic [27:0] exp_mid, exp_out;

  layer_compositor_n #(
    .N_LAYERS(6), .TRANSPARENT_RGB(8'hFF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .resetN(resetN), .drawingRequest(drawingRequest), .layerRGB(layerRGB),
    .backGroundRGB(backGroundRGB), .startOfFrame(startOfFrame), .cfgWrite(cfgWrite),
    .cfgEnable(cfgEnable), .cfgBlinkMask(cfgBlinkMask), .cfgPending(cfgPending),
    .redOut(redOut), .greenOut(greenOut), .blueOut(blueOut),
    .topLayer(topLayer), .topLayerValid(topLayerValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [27:0] ref_pixel(input logic [5:0] dr, input logic [47:0] rgb,
                                            input logic [7:0] bg, input logic [5:0] en,
                                            input logic [5:0] mk, input logic ph);
    int win = -1;
    logic [7:0] c;
    int r, g, b;
    for (int i = 0; i < 6; i++)
      if (win < 0 && dr[i] && en[i] && rgb[8*i +: 8] != 8'hFF && !(mk[i] && ph)) win = i;
    c = (win < 0) ? bg : rgb[8*win +: 8];
    r = c[7:5] * 32 + (c[5] ? 31 : 0);
    g = c[4:2] * 32 + (c[2] ? 31 : 0);
    b = c[1:0] * 64 + (c[0] ? 63 : 0);
    return {(win >= 0), (win < 0) ? 3'd0 : 3'(win), 8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic logic m_phase();
    return ((m_sofs / BF) % 2) == 1;
  endfunction

  function automatic logic [27:0] dut_pixel();
    return {topLayerValid, topLayer, redOut, greenOut, blueOut};
  endfunction

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_en = '1; m_mask = '0; m_sh_en = '1; m_sh_mask = '0;
    m_pend = 1'b0; m_sofs = 0; exp_mid = '0; exp_out = '0;
  endtask

  // One clock: predict from pre-edge inputs, advance model at the edge, check at the negedge
  task automatic tick();
    logic [27:0] now;
    now = ref_pixel(drawingRequest, layerRGB, backGroundRGB, m_en, m_mask, m_phase());
    @(posedge clk);
    exp_out = exp_mid;
    exp_mid = now;
    if (startOfFrame) begin
      if (cfgWrite) begin
        m_en = cfgEnable; m_mask = cfgBlinkMask; m_sh_en = cfgEnable; m_sh_mask = cfgBlinkMask;
      end else begin
        m_en = m_sh_en; m_mask = m_sh_mask;
      end
      m_pend = 1'b0;
      m_sofs++;
    end else if (cfgWrite) begin
      m_sh_en = cfgEnable; m_sh_mask = cfgBlinkMask; m_pend = 1'b1;
    end
    @(negedge clk);
    check("pix", dut_pixel(), exp_out);
    check("pending", 28'(cfgPending), 28'(m_pend));
    $display("tick dr=%b sof=%b wr=%b out=%h exp=%h pend=%b", drawingRequest, startOfFrame,
             cfgWrite, dut_pixel(), exp_out, cfgPending);
  endtask

  task automatic pulse(input logic sof, input logic wr, input logic [5:0] en, input logic [5:0] mk);
    startOfFrame = sof; cfgWrite = wr; cfgEnable = en; cfgBlinkMask = mk;
    tick();
    startOfFrame = 1'b0; cfgWrite = 1'b0;
  endtask

  initial begin
    resetN = 1'b0;
    drawingRequest = '0; layerRGB = '0; backGroundRGB = '0;
    startOfFrame = 1'b0; cfgWrite = 1'b0; cfgEnable = '0; cfgBlinkMask = '0;
    model_reset();
    #3;
    check("rst_pix", dut_pixel(), 28'd0);
    check("rst_pending", 28'(cfgPending), 28'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Background only
    backGroundRGB = 8'h1C;
    tick(); tick();
    check("bg_only", dut_pixel(), {1'b0, 3'd0, 8'h00, 8'hFF, 8'h00});

    // Layer 1 beats layer 3
    drawingRequest = 6'b001010;
    layerRGB[15:8] = 8'hE0; layerRGB[31:24] = 8'h03;
    tick(); tick();
    check("layer1_wins", dut_pixel(), {1'b1, 3'd1, 8'hFF, 8'h00, 8'h00});

    // Transparent layer 1 falls through to layer 3
    layerRGB[15:8] = 8'hFF;
    tick(); tick();
    check("transparent", dut_pixel(), {1'b1, 3'd3, 8'h00, 8'h00, 8'hFF});
    layerRGB[15:8] = 8'hE0;

    // Mid-frame write is held until start of frame
    pulse(1'b0, 1'b1, 6'b111101, 6'b000000);
    tick(); tick();
    check("held_pending", 28'(cfgPending), 28'd1);
    check("held_top", 28'(topLayer), 28'd1);
    pulse(1'b1, 1'b0, 6'b000000, 6'b000000);
    tick(); tick();
    check("applied_pending", 28'(cfgPending), 28'd0);
    check("applied_top", 28'(topLayer), 28'd3);

    // Write coincident with start of frame goes straight to active
    pulse(1'b1, 1'b1, 6'b111111, 6'b000000);
    check("coincident_pending", 28'(cfgPending), 28'd0);
    tick(); tick();
    check("coincident_top", 28'(topLayer), 28'd1);

    // Blink layer 1 across several frames
    pulse(1'b1, 1'b1, 6'b111111, 6'b000010);
    for (int f = 0; f < 8; f++) begin
      pulse(1'b1, 1'b0, 6'b000000, 6'b000000);
      tick(); tick(); tick();
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drawingRequest = 6'($urandom);
      for (int i = 0; i < 6; i++)
        layerRGB[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      backGroundRGB = 8'($urandom);
      pulse(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), 6'($urandom), 6'($urandom));
    end

    // Mid-stream reset with layer 0 winning and a write pending
    pulse(1'b1, 1'b1, 6'b111101, 6'b000010);
    drawingRequest = 6'b000001; layerRGB[7:0] = 8'hE0;
    pulse(1'b0, 1'b1, 6'b000001, 6'b000001);
    tick();
    check("pre_rst_top", dut_pixel(), {1'b1, 3'd0, 8'hFF, 8'h00, 8'h00});
    #2;
    resetN = 1'b0;
    #1;
    check("async_rst_pix", dut_pixel(), 28'd0);
    check("async_rst_pending", 28'(cfgPending), 28'd0);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;

    // Enable back to all ones and blink phase 0: layer 1 visible again
    drawingRequest = 6'b000010; layerRGB[15:8] = 8'hE0;
    tick(); tick();
    check("post_rst_layer1", dut_pixel(), {1'b1, 3'd1, 8'hFF, 8'h00, 8'h00});
    for (int n = 0; n < 100; n++) begin
      drawingRequest = 6'($urandom);
      for (int i = 0; i < 6; i++)
        layerRGB[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      pulse(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 6'($urandom), 6'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
